// File: rtl/apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_bridge_pkg
// Description : Shared types and constants for the APB requester bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_bridge_pkg;

  // PPROT field width
  localparam int APB_PROT_W = 3;

  // Default PREADY wait bound in ACCESS cycles (0 disables the bound)
  localparam int DEF_TIMEOUT_CYC = 256;

  // Widest data bus the response record can carry; narrower buses zero-extend
  localparam int APB_MAX_DATA_W = 64;

  // Bridge control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_br_state_e;

  // Completion record handed back on the response stream
  typedef struct packed {
    logic [APB_MAX_DATA_W-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

  // Error completion that never reached (or never finished on) the bus
  function automatic apb_rsp_t apb_err_rsp(input logic is_timeout);
    apb_rsp_t r;
    r.rdata   = '0;
    r.err     = 1'b1;
    r.timeout = is_timeout;
    return r;
  endfunction

endpackage : apb_bridge_pkg
`default_nettype wire

// File: rtl/apb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : apb_timeout_ctr
// Description : Saturating ACCESS-phase wait counter with expiry flag.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timeout_ctr
  import apb_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A zero bound still needs a one-bit register to keep the code uniform
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count waiting cycles, saturating at the bound; clear has priority
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != C_LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry fires on the wait cycle that would make the count reach the bound
  if (TIMEOUT_CYC > 0) begin : g_exp_on
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYC - 1);
    assign expired = enable && (cnt_q == C_LAST);
  end else begin : g_exp_off
    assign expired = 1'b0;
  end

endmodule : apb_timeout_ctr
`default_nettype wire

// File: rtl/apb_req_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_bridge
// Description : Single-outstanding valid/ready to APB3/APB4 master bridge
//               with bounded PREADY wait and error/timeout reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_bridge
  import apb_bridge_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int NSEL        = 1,
  parameter  int APB4        = 1,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int STRB_W      = DATA_W / 8,
  localparam int SEL_W       = (NSEL > 1) ? $clog2(NSEL) : 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command stream
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_write,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [STRB_W-1:0]     req_strb,
  input  logic [APB_PROT_W-1:0] req_prot,
  input  logic [SEL_W-1:0]      req_sel,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB master
  output logic [ADDR_W-1:0]     PADDR,
  output logic [NSEL-1:0]       PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [APB_PROT_W-1:0] PPROT,
  output logic [STRB_W-1:0]     PSTRB,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // NSEL always fits in SEL_W+1 bits, so the range check cannot wrap
  localparam logic [SEL_W:0] C_NSEL = (SEL_W + 1)'(NSEL);
  localparam bit             C_APB4 = (APB4 != 0);

  apb_br_state_e             state_q, state_d;
  logic [ADDR_W-1:0]         paddr_q, paddr_d;
  logic                      pwrite_q, pwrite_d;
  logic [DATA_W-1:0]         pwdata_q, pwdata_d;
  logic [APB_PROT_W-1:0]     pprot_q, pprot_d;
  logic [STRB_W-1:0]         pstrb_q, pstrb_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  apb_rsp_t                  rsp_q, rsp_d;

  logic                      bad_sel;
  logic                      accept;
  logic                      bus_active;
  logic                      tmo_expired;
  logic                      tmo_clear;
  logic                      tmo_enable;

  assign bad_sel    = ({1'b0, req_sel} >= C_NSEL);
  assign accept     = (state_q == ST_IDLE) && req_valid;
  assign tmo_clear  = (state_q != ST_ACCESS);
  assign tmo_enable = (state_q == ST_ACCESS) && !PREADY;

  apb_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // State register; reset discards any in-flight transfer or response
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: PREADY is tested before expiry so a late PREADY still completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = bad_sel ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || tmo_expired) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; req_ready drops in the reset cycle itself
  always_comb begin
    bus_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    PENABLE    = (state_q == ST_ACCESS);
    rsp_valid  = (state_q == ST_RESP);
    req_ready  = (state_q == ST_IDLE) && !PRESET;
  end

  // One-hot select from the latched slave index
  for (genvar i = 0; i < NSEL; i++) begin : g_psel
    assign PSEL[i] = bus_active && (sel_q == SEL_W'(i));
  end

  // Request fields only change on a bus-bound accept; PWDATA only on writes
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pprot_d  = pprot_q;
    pstrb_d  = pstrb_q;
    sel_d    = sel_q;
    if (accept && !bad_sel) begin
      paddr_d  = req_addr;
      pwrite_d = req_write;
      pprot_d  = C_APB4 ? req_prot : '0;
      pstrb_d  = (C_APB4 && req_write) ? req_strb : '0;
      sel_d    = req_sel;
      if (req_write) begin
        pwdata_d = req_wdata;
      end
    end
  end

  // Completion capture: bad select, slave completion, or wait timeout
  always_comb begin
    rsp_d = rsp_q;
    if (accept && bad_sel) begin
      rsp_d = apb_err_rsp(1'b0);
    end else if (state_q == ST_ACCESS) begin
      if (PREADY) begin
        rsp_d.rdata   = (!pwrite_q && !PSLVERR) ? APB_MAX_DATA_W'(PRDATA) : '0;
        rsp_d.err     = PSLVERR;
        rsp_d.timeout = 1'b0;
      end else if (tmo_expired) begin
        rsp_d = apb_err_rsp(1'b1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pprot_q  <= '0;
      pstrb_q  <= '0;
      sel_q    <= '0;
      rsp_q    <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pprot_q  <= pprot_d;
      pstrb_q  <= pstrb_d;
      sel_q    <= sel_d;
      rsp_q    <= rsp_d;
    end
  end

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PPROT       = pprot_q;
  assign PSTRB       = pstrb_q;
  assign rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule : apb_req_bridge
`default_nettype wire
